aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Iterative AES encryption controller that time-multiplexes one single-round datapath instance across all rounds of a block. It accepts a plaintext block through a valid/ready handshake and performs the initial AddRoundKey itself. It then issues rounds 1..Nr to the round datapath, fetching each round key from an external key store by index. The ciphertext is returned through a valid/ready handshake. It sits between the block-level input FIFO and the shared round datapath / expanded-key RAM.

Parameters:
DATA_WIDTH, 128, block and round-key width; fixed at 128.
ROUND_LAT, 1, nominal round datapath latency in cycles; used only by the bench and for latency figures.
TIMEOUT, 15, maximum cycles spent in WAIT before aborting with an error.

Ports:
clk  in  1  system clock, all logic rising-edge.
rst  in  1  synchronous, active-high reset.
key_len  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled on accept.
in_valid  in  1  plaintext valid.
in_ready  out  1  sequencer can accept a block.
in_data  in  128  plaintext block.
rk_idx  out  4  round-key index into the key store (combinational read).
rk_data  in  128  round key at rk_idx, same cycle.
rnd_valid  out  1  one-cycle issue strobe to the round datapath.
rnd_state  out  128  state presented to the round datapath.
rnd_key  out  128  round key for the current round; held stable from ISSUE through WAIT.
rnd_final  out  1  high when the current round is round Nr (datapath skips MixColumns).
rnd_valid_in  in  1  round datapath result valid.
rnd_state_in  in  128  round datapath result.
out_valid  out  1  ciphertext valid.
out_ready  in  1  downstream accepts ciphertext.
out_data  out  128  ciphertext block.
busy  out  1  high in any state other than IDLE.
err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Reset (rst=1 at a clock edge):
  - state <= IDLE; round_cnt <= 0; state_reg <= 0; len_reg <= 0; tmo_cnt <= 0; err <= 0.
  - All outputs are deasserted or zero except in_ready=1.
  - Reset mid-block discards the block; no out_valid follows.
- IDLE:
  - in_ready=1; rk_idx=0.
  - On in_valid: state_reg <= in_data ^ rk_data; len_reg <= key_len; round_cnt <= 1; go to ISSUE.
- ISSUE:
  - rnd_valid=1 for exactly one cycle; rnd_state=state_reg; rk_idx=round_cnt; rnd_key=rk_data.
  - rnd_final = (round_cnt == Nr), where Nr = 10 if len_reg=0, else 14.
  - tmo_cnt <= 0; go to WAIT.
- WAIT:
  - rk_idx, rnd_key, rnd_state and rnd_final are held; rnd_valid=0.
  - On rnd_valid_in: state_reg <= rnd_state_in.
    - If round_cnt == Nr, go to DONE.
    - Otherwise round_cnt <= round_cnt + 1 and go to ISSUE.
  - If no response arrives, tmo_cnt increments. When it reaches TIMEOUT: err <= 1, go to IDLE, block dropped.
- DONE:
  - out_valid=1; out_data=state_reg.
  - Hold until out_ready, then go to IDLE. out_data stays stable while stalled.
- Spurious rnd_valid_in (any state except WAIT): ignored for data; sets err <= 1.
- Latency with ROUND_LAT=1:
  - Round k is issued at cycle 2k-1 after the accept cycle (cycle 0).
  - out_valid is first high at cycle 21 (AES-128) or 29 (AES-256).
- key_len changes after accept have no effect on the block in flight.
- There is no back-to-back overlap: in_ready=0 from accept until the DONE->IDLE transition. Throughput is one block per 22/30 cycles minimum.

Decomposition:
- Package aes_ctrl_pkg:
  - FSM state enum (2 bits).
  - NR_128=10, NR_256=14.
  - RK_IDX_W=4, DATA_WIDTH=128.
- Sub-module aes_timeout_cnt: clear/enable/expire counter, parameterised by TIMEOUT.
- Everything else is a single FSM module.

Test Plan:
- AES-128 FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff, behavioural key store plus round model -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid first at cycle 21; rnd_final high only on round 10.
- AES-256 FIPS-197 C.3: key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089; out_valid at cycle 29; rk_idx sequence 0,1..14.
- Output backpressure: out_ready held low 5 cycles -> out_valid and out_data stable for 5 cycles, in_ready=0 throughout; IDLE one cycle after out_ready.
- Reset mid-operation: assert rst during WAIT of round 4 -> next cycle busy=0, in_ready=1, err=0, no out_valid; a following block encrypts correctly.
- Timeout: round model withholds rnd_valid_in -> after 15 WAIT cycles, err=1, return to IDLE; err remains 1 until rst.
- Spurious response: pulse rnd_valid_in while in IDLE -> err=1, state_reg unchanged; a subsequent block still produces the correct ciphertext.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_ctrl_pkg;
  localparam int DATA_WIDTH = 128;
  localparam int RK_IDX_W   = 4;
  localparam int ROUND_LAT  = 1;

  localparam logic [RK_IDX_W-1:0] NR_128 = 4'd10;
  localparam logic [RK_IDX_W-1:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  function automatic logic [RK_IDX_W-1:0] nr_of(input logic len);
    return len ? NR_256 : NR_128;
  endfunction
endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in, key-store, round-datapath and block-out signals of the AES sequencer.
interface aes_round_sequencer_if;
  import aes_ctrl_pkg::*;

  logic                  key_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [RK_IDX_W-1:0]   rk_idx;
  logic [DATA_WIDTH-1:0] rk_data;
  logic                  rnd_valid;
  logic [DATA_WIDTH-1:0] rnd_state;
  logic [DATA_WIDTH-1:0] rnd_key;
  logic                  rnd_final;
  logic                  rnd_valid_in;
  logic [DATA_WIDTH-1:0] rnd_state_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  busy;
  logic                  err;

  modport master (
    input  key_len, in_valid, in_data, rk_data, rnd_valid_in, rnd_state_in, out_ready,
    output in_ready, rk_idx, rnd_valid, rnd_state, rnd_key, rnd_final, out_valid, out_data,
           busy, err
  );

  modport slave (
    output key_len, in_valid, in_data, rk_data, rnd_valid_in, rnd_state_in, out_ready,
    input  in_ready, rk_idx, rnd_valid, rnd_state, rnd_key, rnd_final, out_valid, out_data,
           busy, err
  );
endinterface

// File: rtl/aes_timeout_cnt.sv
// Round-response watchdog: counts enabled cycles, flags expiry on the TIMEOUT-th one.
module aes_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer sharing one round datapath across rounds 1..Nr.
// States: IDLE accept + initial AddRoundKey | ISSUE strobe one round | WAIT await result | DONE hold ciphertext
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  aes_round_sequencer_if.master bus
);
  seq_state_t            r_state;
  logic [RK_IDX_W-1:0]   r_round_cnt;
  logic [DATA_WIDTH-1:0] r_state_reg;
  logic [DATA_WIDTH-1:0] r_rnd_key;
  logic                  r_len;
  logic                  r_final;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_rnd_valid;
  logic                  r_out_valid;
  logic                  r_err;

  logic [RK_IDX_W-1:0]   w_nr;
  logic [RK_IDX_W-1:0]   w_next_cnt;
  logic                  w_tmo_clr;
  logic                  w_tmo_en;
  logic                  w_expire;

  assign w_nr       = nr_of(r_len);
  assign w_next_cnt = r_round_cnt + RK_IDX_W'(1);
  assign w_tmo_clr  = (r_state != ST_WAIT);
  assign w_tmo_en   = (r_state == ST_WAIT) && !bus.rnd_valid_in;

  aes_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.rk_idx    = r_round_cnt;
  assign bus.rnd_valid = r_rnd_valid;
  assign bus.rnd_state = r_state_reg;
  // Key store reads combinationally, so ISSUE passes it through; WAIT replays the captured copy.
  assign bus.rnd_key   = (r_state == ST_ISSUE) ? bus.rk_data : r_rnd_key;
  assign bus.rnd_final = r_final;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_state_reg;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_round_cnt <= '0;
      r_state_reg <= '0;
      r_rnd_key   <= '0;
      r_len       <= 1'b0;
      r_final     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_rnd_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rnd_valid <= 1'b0;
      if (bus.rnd_valid_in && (r_state != ST_WAIT)) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_state_reg <= bus.in_data ^ bus.rk_data;
          r_len       <= bus.key_len;
          r_round_cnt <= RK_IDX_W'(1);
          r_final     <= (RK_IDX_W'(1) == nr_of(bus.key_len));
          r_rnd_valid <= 1'b1;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_rnd_key <= bus.rk_data;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: if (bus.rnd_valid_in) begin
          r_state_reg <= bus.rnd_state_in;
          if (r_round_cnt == w_nr) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_round_cnt <= w_next_cnt;
            r_final     <= (w_next_cnt == w_nr);
            r_rnd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end else if (w_expire) begin
          r_err       <= 1'b1;
          r_round_cnt <= '0;
          r_final     <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        ST_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_round_cnt <= '0;
          r_final     <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural key store and AES round model, FIPS-197 vectors.
module tb_aes_round_sequencer;
  import aes_ctrl_pkg::*;

  typedef struct {
    logic         len;
    logic [127:0] pt;
    logic [127:0] ct;
    int           stall;
    bit           flip;
  } vec_t;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_round_sequencer_if bus();
  aes_round_sequencer #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]   sb_t [256];
  logic [127:0] ks [2][16];
  logic         ks_sel   = 1'b0;
  logic         m_valid  = 1'b0;
  logic         spur     = 1'b0;
  logic         withhold = 1'b0;
  logic [127:0] m_data   = '0;
  logic [127:0] sb_q [$];
  int           n_chk = 0;
  int           n_err = 0;
  vec_t         vecs [4];

  assign bus.rk_data      = ks[ks_sel][bus.rk_idx];
  assign bus.rnd_valid_in = m_valid | spur;
  assign bus.rnd_state_in = spur ? 128'hdeadbeef_cafef00d_01234567_89abcdef : m_data;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
        b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int sel);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Round datapath model: answers each issue strobe ROUND_LAT (=1) cycle later.
  always begin
    logic [127:0] resp;
    @(negedge clk);
    if (bus.rnd_valid && !withhold) begin
      resp = aes_round(bus.rnd_state, bus.rnd_key, bus.rnd_final);
      @(posedge clk); #1;
      m_valid = 1'b1;
      m_data  = resp;
      @(posedge clk); #1;
      m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_block(input logic len, input logic [127:0] pt);
    @(negedge clk);
    ks_sel       = len;
    bus.key_len  = len;
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '1;
  endtask

  task automatic run_block(input vec_t v);
    int           nr, lat, cyc, rounds;
    bit           got;
    logic [127:0] exp;
    nr  = v.len ? 14 : 10;
    lat = 1 + nr * (ROUND_LAT + 1);
    @(negedge clk);
    chk("idle_in_ready", 128'(bus.in_ready), 128'(1));
    chk("idle_rk_idx", 128'(bus.rk_idx), 128'(0));
    sb_q.push_back(v.ct);
    drive_block(v.len, v.pt);
    if (v.flip) bus.key_len = ~v.len;
    cyc = 0; rounds = 0; got = 1'b0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.rnd_valid) begin
        rounds++;
        chk("issue_cycle", 128'(cyc), 128'(2*rounds-1));
        chk("rk_idx", 128'(bus.rk_idx), 128'(rounds));
        chk("rnd_key", bus.rnd_key, ks[v.len][rounds[3:0]]);
        chk("rnd_final", 128'(bus.rnd_final), 128'(rounds == nr));
      end
      if (bus.out_valid) got = 1'b1;
      else chk("busy_in_ready", 128'(bus.in_ready), 128'(0));
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL out_valid_wait: none within %0d cycles, required at cycle %0d", cyc, lat);
      sb_q.delete();
      return;
    end
    chk("out_latency", 128'(cyc), 128'(lat));
    chk("rounds_issued", 128'(rounds), 128'(nr));
    exp = sb_q.pop_front();
    chk("out_data", bus.out_data, exp);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_out_data", bus.out_data, exp);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_out_valid", 128'(bus.out_valid), 128'(0));
    chk("post_busy", 128'(bus.busy), 128'(0));
    chk("post_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int rounds, cyc;
    bit seen;
    bus.key_len   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) sb_t[i] = sbox(8'(i));
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 16; r++) ks[s][r] = '0;
    expand(KEY128, 4, 0);
    expand(KEY256, 8, 1);

    vecs[0] = '{len: 1'b0, pt: PT, ct: CT128, stall: 0, flip: 1'b0};
    vecs[1] = '{len: 1'b1, pt: PT, ct: CT256, stall: 0, flip: 1'b0};
    vecs[2] = '{len: 1'b0, pt: PT, ct: CT128, stall: 5, flip: 1'b1};
    vecs[3] = '{len: 1'b1, pt: PT, ct: CT256, stall: 2, flip: 1'b1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_err", 128'(bus.err), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_rnd_valid", 128'(bus.rnd_valid), 128'(0));
    chk("rst_rnd_final", 128'(bus.rnd_final), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));

    for (int i = 0; i < 4; i++) run_block(vecs[i]);

    // Reset while round 4 is outstanding.
    drive_block(1'b0, PT);
    rounds = 0; cyc = 0;
    while (rounds < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.rnd_valid) rounds++;
    end
    chk("mid_reach_round4", 128'(rounds), 128'(4));
    @(negedge clk);
    chk("mid_wait_busy", 128'(bus.busy), 128'(1));
    pulse_reset();
    @(negedge clk);
    chk("mid_rst_busy", 128'(bus.busy), 128'(0));
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_err", 128'(bus.err), 128'(0));
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_out", 128'(seen), 128'(0));
    run_block(vecs[1]);

    // Round model stays silent: 15 WAIT cycles then abort.
    withhold = 1'b1;
    drive_block(1'b0, PT);
    @(negedge clk);
    chk("tmo_issue", 128'(bus.rnd_valid), 128'(1));
    repeat (15) @(negedge clk);
    chk("tmo_last_wait_busy", 128'(bus.busy), 128'(1));
    chk("tmo_last_wait_err", 128'(bus.err), 128'(0));
    @(negedge clk);
    withhold = 1'b0;
    chk("tmo_busy", 128'(bus.busy), 128'(0));
    chk("tmo_err", 128'(bus.err), 128'(1));
    chk("tmo_in_ready", 128'(bus.in_ready), 128'(1));
    chk("tmo_no_out", 128'(bus.out_valid), 128'(0));
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", 128'(bus.err), 128'(1));
    run_block(vecs[0]);
    chk("tmo_err_after_block", 128'(bus.err), 128'(1));
    pulse_reset();
    @(negedge clk);
    chk("tmo_err_cleared", 128'(bus.err), 128'(0));

    // Stray round response while idle.
    run_block(vecs[0]);
    @(negedge clk);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_err", 128'(bus.err), 128'(1));
    chk("spur_state_kept", bus.rnd_state, CT128);
    chk("spur_busy", 128'(bus.busy), 128'(0));
    run_block(vecs[1]);
    chk("spur_err_sticky", 128'(bus.err), 128'(1));

    chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
